// File: rtl/sp_ram_fifo_ctrl_pkg.sv
// Shared widths, depth derivation and the grant encoding for the
// single-port-RAM FIFO controller.
package sp_ram_fifo_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned ADDR_W_DEF = 6;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    localparam int unsigned DEPTH_DEF = depth_of(ADDR_W_DEF);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WRITE,
        GRANT_READ
    } grant_t;

endpackage

// File: rtl/sp_ram_fifo_ctrl_arb.sv
// Two-requester round-robin arbiter: on contention the requester that did
// not win last time gets the grant.
module rr_arb2
    import sp_ram_fifo_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_w,
    input  logic req_r,
    output logic gnt_w,
    output logic gnt_r
);

    grant_t last_grant_q;
    grant_t last_grant_d;
    grant_t grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_READ;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        grant = GRANT_NONE;
        if (req_w && (!req_r || last_grant_q != GRANT_WRITE)) begin
            grant = GRANT_WRITE;
        end else if (req_r) begin
            grant = GRANT_READ;
        end
    end

    // Idle cycles leave the history untouched so fairness survives gaps.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant != GRANT_NONE) begin
            last_grant_d = grant;
        end
    end

    always_comb begin
        gnt_w = (grant == GRANT_WRITE);
        gnt_r = (grant == GRANT_READ);
    end

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM with registered read;
// push and pop share the one RAM port through a round-robin arbiter.
module sp_ram_fifo_ctrl
    import sp_ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_hold_q, rd_hold_d;

    logic push_elig;
    logic pop_elig;
    logic gnt_w;
    logic gnt_r;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH);
    assign count = count_q;

    // Handshakes are forced low while reset is held, not just after it.
    assign push_elig = wr_valid & ~full  & ~rst;
    assign pop_elig  = rd_req   & ~empty & ~rst;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_w (push_elig),
        .req_r (pop_elig),
        .gnt_w (gnt_w),
        .gnt_r (gnt_r)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = gnt_r;
        rd_hold_d  = rd_hold_q;
        if (gnt_w) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
        end else if (gnt_r) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
        end
        if (rd_valid_q) begin
            rd_hold_d = ram_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_hold_q  <= rd_hold_d;
        end
    end

    // rd_data passes the RAM word through in the valid cycle, else holds.
    assign rd_data  = rd_valid_q ? ram_dout : rd_hold_q;
    assign rd_valid = rd_valid_q;

    assign wr_ready = gnt_w;
    assign rd_ack   = gnt_r;
    assign ram_we   = gnt_w;
    assign ram_addr = gnt_w ? wr_ptr_q : rd_ptr_q;
    assign ram_din  = wr_data;

endmodule
